// File: rtl/mux_sel_arbiter.sv
// Round-robin 8:1 mux-select arbiter: one-hot grant plus binary sel, released on done or a request drop.
// Optional hold-timeout forced release compiled in with MUX_ARB_TIMEOUT_EN.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic       timeout_q, timeout_d;
    logic [2:0] winner;
    logic [2:0] candIdx;
    logic       found;
    logic       holdExpired;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_sel_arbiter: MAX_HOLD must be in 1..255");
    end

    // Search upward from the requester after the last winner; offset 8 wraps back to last itself.
    always_comb begin
        winner  = last_q;
        found   = 1'b0;
        candIdx = last_q;
        for (int i = 1; i <= 8; i++) begin
            candIdx = last_q + 3'(i);
            if (!found && req[candIdx]) begin
                winner = candIdx;
                found  = 1'b1;
            end
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] holdCnt_q, holdCnt_d;

    assign holdExpired = (holdCnt_q == 8'(MAX_HOLD - 1));

    always_comb begin
        holdCnt_d = 8'd0;
        if (state_q == GRANT) begin
            holdCnt_d = holdCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdCnt_q <= 8'd0;
        end else begin
            holdCnt_q <= holdCnt_d;
        end
    end
`else
    assign holdExpired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = 8'b1 << winner;
                    sel_d   = winner;
                    last_d  = winner;
                end
            end
            GRANT: begin
                // A normal release takes precedence so timeout only flags a genuinely forced release.
                if (done || !req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 8'd0;
                end else if (holdExpired) begin
                    state_d   = IDLE;
                    grant_d   = 8'd0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 8'd0;
            sel_q     <= 3'd0;
            last_q    <= 3'd7;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = |grant_q;
    assign timeout = timeout_q;

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of cycles one grant is held when the timeout feature is compiled in (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 8 bits: per-requester request for the shared 8:1 mux path; bit i is requester i.
REQ-005 SHALL have port done, input, 1 bit: the current grant holder has finished with the mux.
REQ-006 SHALL have port grant, output, 8 bits: one-hot grant, or all-zero when idle.
REQ-007 SHALL have port sel, output, 3 bits: binary index of the granted requester, driven straight to the mux select.
REQ-008 SHALL have port busy, output, 1 bit: high whenever grant is non-zero.
REQ-009 SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 In IDLE with req non-zero, SHALL select the first set req bit searching upward from (last+1) mod 8, wrapping past 7 to 0; the grant is registered and visible the next cycle (1-cycle latency).
REQ-012 In IDLE with req equal to zero, SHALL remain in IDLE with grant=0 and sel holding its previous value.
REQ-013 On entering GRANT, SHALL set grant to a one-hot value, set sel to the winner index, and set last to the winner index.
REQ-014 In GRANT, SHALL hold grant and sel stable until a release event occurs.
REQ-015 Release events SHALL be: done=1; req bit of the holder dropping to 0; or a timeout (REQ-023).
REQ-016 On a release event, SHALL return to IDLE the next cycle with grant=0; the earliest re-grant is one cycle later, so exactly one idle cycle occurs between grants.
REQ-017 done asserted in IDLE SHALL be ignored.
REQ-018 Simultaneous done and a holder req drop SHALL count as one release.
REQ-019 Requests from non-holders during GRANT SHALL have no effect until the FSM is back in IDLE.
REQ-020 grant SHALL never have more than one bit set; sel SHALL always equal the index of the set grant bit while busy=1.

Reset
REQ-021 While reset_n=0, SHALL force: state=IDLE, grant=0, sel=0, busy=0, timeout=0, last=7 (so requester 0 has first priority), and hold counter=0.
REQ-022 Reset asserted mid-GRANT SHALL drop grant immediately, asynchronously and without waiting for clk; after deassertion, arbitration restarts from last=7.

Configuration
REQ-023 With macro MUX_ARB_TIMEOUT_EN defined:
- an 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
- when the count reaches MAX_HOLD-1 without another release, the block SHALL force a release and pulse timeout high for the same cycle grant drops.
- a MAX_HOLD-cycle grant therefore ends on its MAX_HOLD-th cycle.
REQ-024 Without MUX_ARB_TIMEOUT_EN, SHALL omit the counter; timeout is tied to 0 and grants are released only by done or a req drop.

Verification
REQ-025 Reset with req=8'h00 -> grant=0, sel=0, busy=0; then req=8'h01 -> grant=8'h01, sel=0 one cycle later.
REQ-026 req=8'hFF held, done pulsed each GRANT -> successive sel values 0,1,2,...,7,0 (wrap), one idle cycle between grants.
REQ-027 last=5, req=8'h21 -> sel=0 (search wraps 6,7,0); next round with req=8'h21 -> sel=5.
REQ-028 Holder 3 granted, req[3] dropped with done=0 -> grant=0 next cycle; req[6] asserted meanwhile -> sel=6 granted after the idle cycle.
REQ-029 Timeout: MUX_ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=8'h04, done never asserted -> grant high for exactly 4 cycles, timeout=1 on the release cycle, then re-grant to 2 after 1 idle cycle. Macro undefined -> grant stays high indefinitely and timeout=0.
REQ-030 Reset mid-grant: reset_n=0 while sel=4 -> grant=0 before the next clk edge; after release with req=8'h11 -> sel=0 first.
